// File: rtl/z16_fetch_unit.sv
// Z16 instruction fetch stage.
// Owns the fetch PC, issues 16-bit reads to instruction memory, buffers
// returned words together with their PCs, and hands them to decode over a
// valid/ready handshake. A redirect flushes the buffers and drops any
// responses that are still in flight. A halt stops new fetches.
module z16_fetch_unit #(
  parameter logic [15:0] RESET_PC        = 16'h0000,
  parameter int          FIFO_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [15:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [15:0] i_imem_rdata,
  output logic [15:0] o_instr,
  output logic [15:0] o_pc,
  output logic        o_valid,
  input  logic        i_ready,
  input  logic        i_redirect,
  input  logic [15:0] i_redirect_pc,
  input  logic        i_halt,
  output logic        o_halted
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HALT
  } state_t;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } entry_t;

  state_t state_q, state_d;

  logic [15:0]      fetch_pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] discard;

  // PC queue: PCs of issued requests awaiting their response, in order.
  logic [15:0]      pcq_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] pcq_wr, pcq_rd;

  // Instruction buffer towards decode.
  entry_t           fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] fifo_wr, fifo_rd;
  logic [CNT_W-1:0] fifo_count;

  logic             issue;
  logic             resp_keep;
  logic             push;
  logic             pop;
  logic [CNT_W:0]   inflight;

  // Credits: every accepted request already owns a buffer slot, so the
  // instruction buffer cannot overflow when responses arrive.
  assign inflight  = {1'b0, fifo_count} + {1'b0, outstanding};
  assign issue     = o_imem_req & i_imem_gnt;
  assign resp_keep = i_imem_rvalid & (discard == '0);
  assign push      = resp_keep & ~i_redirect;
  assign pop       = o_valid & i_ready & ~i_redirect;

  assign o_imem_addr = fetch_pc;
  assign o_valid     = (fifo_count != '0);
  assign o_instr     = o_valid ? fifo_mem[fifo_rd].instr : 16'h0000;
  assign o_pc        = o_valid ? fifo_mem[fifo_rd].pc    : 16'h0000;

  // State register.
  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples the values from before the clock edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_BOOT;
    else          state_q <= state_d;
  end

  // Next-state logic: redirect always lands in RUN, halt only counts in RUN.
  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  if (!i_redirect && i_halt) state_d = ST_HALT;
      ST_HALT: if (i_redirect) state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
  end

  // Output logic: issue fetches in RUN while credits remain.
  always_comb begin
    o_imem_req = 1'b0;
    o_halted   = 1'b0;
    unique case (state_q)
      ST_RUN:  o_imem_req = ~i_redirect && (outstanding < MAX_OUT_C) &&
                            (inflight < {1'b0, DEPTH_C});
      ST_HALT: o_halted = 1'b1;
      default: ;
    endcase
  end

  // Fetch PC: jump on redirect, step by one halfword on every accepted request.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)        fetch_pc <= RESET_PC;
    else if (i_redirect) fetch_pc <= i_redirect_pc & 16'hFFFE;
    else if (issue)      fetch_pc <= fetch_pc + 16'd2;
  end

  // Outstanding and discard counters. On redirect, everything still in
  // flight (less a response consumed this cycle) becomes stale.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      outstanding <= '0;
      discard     <= '0;
    end else if (i_redirect) begin
      outstanding <= outstanding - CNT_W'(i_imem_rvalid);
      discard     <= outstanding - CNT_W'(i_imem_rvalid);
    end else begin
      unique case ({issue, i_imem_rvalid})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: ;
      endcase
      if (i_imem_rvalid && discard != '0) discard <= discard - 1'b1;
    end
  end

  // PC queue pointers: push on issue, pop on each kept response, flush on redirect.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pcq_wr <= '0;
      pcq_rd <= '0;
    end else if (i_redirect) begin
      pcq_wr <= '0;
      pcq_rd <= '0;
    end else begin
      if (issue)     pcq_wr <= pcq_wr + 1'b1;
      if (resp_keep) pcq_rd <= pcq_rd + 1'b1;
    end
  end

  // PC queue storage.
  // NOTE: storage arrays carry no reset; the pointers and counts alone decide
  // which entries are meaningful.
  always_ff @(posedge i_clk) begin
    if (issue) pcq_mem[pcq_wr] <= fetch_pc;
  end

  // Instruction buffer pointers and occupancy; push and pop together hold the count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fifo_wr    <= '0;
      fifo_rd    <= '0;
      fifo_count <= '0;
    end else if (i_redirect) begin
      fifo_wr    <= '0;
      fifo_rd    <= '0;
      fifo_count <= '0;
    end else begin
      if (push) fifo_wr <= fifo_wr + 1'b1;
      if (pop)  fifo_rd <= fifo_rd + 1'b1;
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase
    end
  end

  // Instruction buffer storage: each kept response is paired with its PC.
  always_ff @(posedge i_clk) begin
    if (push) fifo_mem[fifo_wr] <= '{pc: pcq_mem[pcq_rd], instr: i_imem_rdata};
  end

  // Memory must never return a word that was not requested.
  rvalid_needs_outstanding: assert property (
    @(posedge i_clk) disable iff (!i_rst_n) i_imem_rvalid |-> (outstanding != '0));

endmodule
